// File: rtl/axi_lite_read_master.sv
// Single-outstanding AXI4-Lite read initiator: core request/response port in, AR/R channels out.
// Misaligned requests are rejected locally; a hung slave is reported via an R-channel timeout.
module axi_lite_read_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] o_resp_data,
  output logic [1:0]        o_resp_err,
  output logic              o_resp_timeout,
  output logic [ADDR_W-1:0] o_axi_araddr,
  output logic              o_axi_arvalid,
  input  logic              i_axi_arready,
  input  logic [DATA_W-1:0] i_axi_rdata,
  input  logic [1:0]        i_axi_rresp,
  input  logic              i_axi_rvalid,
  output logic              o_axi_rready
);

  localparam int unsigned TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  localparam logic [1:0] ERR_OK     = 2'b00;
  localparam logic [1:0] ERR_SLAVE  = 2'b10;
  localparam logic [1:0] ERR_DECODE = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R_WAIT,
    RESP,
    DRAIN
  } state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   araddr_d;
  logic [DATA_W-1:0]   data_d;
  logic [1:0]          err_d;
  logic                tmo_d;
  logic                pending_drain, pending_drain_d;
  logic [TIMER_W-1:0]  timer, timer_d;

  // State and payload registers; handshake outputs are decoded from the next state so they stay registered.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state          <= IDLE;
      o_axi_araddr   <= '0;
      o_resp_data    <= '0;
      o_resp_err     <= ERR_OK;
      o_resp_timeout <= 1'b0;
      pending_drain  <= 1'b0;
      timer          <= '0;
      o_req_ready    <= 1'b1;
      o_axi_arvalid  <= 1'b0;
      o_axi_rready   <= 1'b0;
      o_resp_valid   <= 1'b0;
    end else begin
      state          <= state_d;
      o_axi_araddr   <= araddr_d;
      o_resp_data    <= data_d;
      o_resp_err     <= err_d;
      o_resp_timeout <= tmo_d;
      pending_drain  <= pending_drain_d;
      timer          <= timer_d;
      o_req_ready    <= (state_d == IDLE);
      o_axi_arvalid  <= (state_d == AR);
      o_axi_rready   <= (state_d == R_WAIT) || (state_d == DRAIN) ||
                        ((state_d == RESP) && pending_drain_d);
      o_resp_valid   <= (state_d == RESP);
    end
  end

  // Next-state and payload update logic.
  always_comb begin
    state_d         = state;
    araddr_d        = o_axi_araddr;
    data_d          = o_resp_data;
    err_d           = o_resp_err;
    tmo_d           = o_resp_timeout;
    pending_drain_d = pending_drain;
    timer_d         = timer;

    case (state)
      IDLE: begin
        if (i_req_valid && o_req_ready) begin
          araddr_d = i_req_addr;
          tmo_d    = 1'b0;
          if (i_req_addr[1:0] != 2'b00) begin
            state_d = RESP;
            data_d  = '0;
            err_d   = ERR_DECODE;
          end else begin
            state_d = AR;
          end
        end
      end

      AR: begin
        if (i_axi_arready) begin
          state_d = R_WAIT;
          timer_d = '0;
        end
      end

      R_WAIT: begin
        timer_d = timer + TIMER_W'(1);
        // A beat arriving on the last allowed cycle still counts as a normal response.
        if (i_axi_rvalid) begin
          state_d = RESP;
          tmo_d   = 1'b0;
          case (i_axi_rresp)
            2'b10: begin
              data_d = '0;
              err_d  = ERR_SLAVE;
            end
            2'b11: begin
              data_d = '0;
              err_d  = ERR_DECODE;
            end
            default: begin
              data_d = i_axi_rdata;
              err_d  = ERR_OK;
            end
          endcase
        end else if ((TIMEOUT != 0) && (timer == TIMER_LAST)) begin
          state_d         = RESP;
          data_d          = '0;
          err_d           = ERR_DECODE;
          tmo_d           = 1'b1;
          pending_drain_d = 1'b1;
        end
      end

      RESP: begin
        if (o_axi_rready && i_axi_rvalid) begin
          pending_drain_d = 1'b0;
        end
        if (i_resp_ready) begin
          state_d = pending_drain_d ? DRAIN : IDLE;
        end
      end

      DRAIN: begin
        if (i_axi_rvalid) begin
          pending_drain_d = 1'b0;
          state_d         = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_read_master.sv
// Scoreboard bench for axi_lite_read_master: directed requests push expected responses,
// an independent monitor pops and compares whenever a response is presented.
module tb_axi_lite_read_master;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic [1:0]    resp_err;
  logic          resp_tmo;
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;

  axi_lite_read_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_addr     (req_addr),
    .o_resp_valid   (resp_valid),
    .i_resp_ready   (resp_ready),
    .o_resp_data    (resp_data),
    .o_resp_err     (resp_err),
    .o_resp_timeout (resp_tmo),
    .o_axi_araddr   (araddr),
    .o_axi_arvalid  (arvalid),
    .i_axi_arready  (arready),
    .i_axi_rdata    (rdata),
    .i_axi_rresp    (rresp),
    .i_axi_rvalid   (rvalid),
    .o_axi_rready   (rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  err;
    logic        tmo;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   ar_count = 0;
  int   exp_ar = 0;
  int   req_hs = 0;
  int   resp_count = 0;
  int   r_beat_cyc = 0;
  int   hs2 = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (arvalid && arready) ar_count <= ar_count + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: compare every presented response cycle against the head of the scoreboard.
  bit seen = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && resp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: actual data=%0h err=%0h required no response", resp_data, resp_err);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            if (sb[0].lat >= 0) chk("resp_latency", 64'(cyc - req_hs), 64'(sb[0].lat));
          end
          chk("resp_data", 64'(resp_data), 64'(sb[0].data));
          chk("resp_err", 64'(resp_err), 64'(sb[0].err));
          chk("resp_timeout", 64'(resp_tmo), 64'(sb[0].tmo));
          if (resp_ready) begin
            void'(sb.pop_front());
            seen = 1'b0;
            resp_count++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] e,
                       input logic t, input int lat, input bit push);
    bit ok = 1'b0;
    if (push) begin
      exp_t x;
      x.data = d;
      x.err  = e;
      x.tmo  = t;
      x.lat  = lat;
      sb.push_back(x);
    end
    req_valid = 1'b1;
    req_addr  = a;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (req_ready) begin
        req_hs = cyc;
        ok     = 1'b1;
      end
      tick();
    end
    req_valid = 1'b0;
    chk("req_accepted", 64'(ok), 64'(1));
  endtask

  task automatic slave_txn(input logic [31:0] a, input int ar_wait, input int r_gap,
                           input bit send_r, input logic [31:0] d, input logic [1:0] r);
    int n = 0;
    @(negedge clk);
    while (!arvalid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!arvalid) begin
      checks++;
      errors++;
      $display("FAIL ar_seen: actual arvalid=0 required 1");
      return;
    end
    for (int k = 0; k < ar_wait; k++) begin
      chk("arvalid_held", 64'(arvalid), 64'(1));
      chk("araddr_held", 64'(araddr), 64'(a));
      @(negedge clk);
    end
    chk("araddr", 64'(araddr), 64'(a));
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    if (!send_r) return;
    repeat (r_gap) @(negedge clk);
    rvalid = 1'b1;
    rdata  = d;
    rresp  = r;
    n = 0;
    while (!rready && n < 300) begin
      @(negedge clk);
      n++;
    end
    r_beat_cyc = cyc;
    chk("rready_for_beat", 64'(rready), 64'(1));
    @(negedge clk);
    rvalid = 1'b0;
    rdata  = '0;
    rresp  = 2'b00;
  endtask

  task automatic wait_resp(input int target);
    int n = 0;
    while (resp_count < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("resp_count", 64'(resp_count), 64'(target));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(1));
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
    chk({tag, "_arvalid"}, 64'(arvalid), 64'(0));
    chk({tag, "_rready"}, 64'(rready), 64'(0));
    chk({tag, "_araddr"}, 64'(araddr), 64'(0));
    chk({tag, "_data"}, 64'(resp_data), 64'(0));
    chk({tag, "_err"}, 64'(resp_err), 64'(0));
    chk({tag, "_timeout"}, 64'(resp_tmo), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    resp_ready = 1'b1;
    arready    = 1'b0;
    rvalid     = 1'b0;
    rdata      = '0;
    rresp      = 2'b00;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst = 1'b0;
    tick();

    // Zero-wait slave: response three cycles after the request handshake, one AR.
    fork
      slave_txn(32'hA000_0048, 0, 0, 1'b1, 32'h1234_5678, 2'b00);
      issue(32'hA000_0048, 32'h1234_5678, 2'b00, 1'b0, 3, 1'b1);
    join
    exp_ar++;
    wait_resp(1);
    chk("ar_count_single", 64'(ar_count), 64'(exp_ar));
    tick();

    // arready low for five cycles.
    fork
      slave_txn(32'h0000_1000, 5, 0, 1'b1, 32'h0BAD_F00D, 2'b00);
      issue(32'h0000_1000, 32'h0BAD_F00D, 2'b00, 1'b0, 8, 1'b1);
    join
    exp_ar++;
    wait_resp(2);
    tick();

    // Misaligned: local decode error, no bus traffic.
    issue(32'h8000_0002, 32'h0, 2'b11, 1'b0, 1, 1'b1);
    wait_resp(3);
    chk("ar_count_misaligned", 64'(ar_count), 64'(exp_ar));
    tick();

    // SLVERR with a stalled core: response held while resp_ready is low.
    resp_ready = 1'b0;
    fork
      slave_txn(32'h0000_0010, 0, 0, 1'b1, 32'hDEAD_BEEF, 2'b10);
      issue(32'h0000_0010, 32'h0, 2'b10, 1'b0, 3, 1'b1);
    join
    exp_ar++;
    for (int n = 0; n < 50 && !resp_valid; n++) @(negedge clk);
    chk("stall_valid_0", 64'(resp_valid), 64'(1));
    @(negedge clk);
    chk("stall_valid_1", 64'(resp_valid), 64'(1));
    @(negedge clk);
    chk("stall_valid_2", 64'(resp_valid), 64'(1));
    tick();
    resp_ready = 1'b1;
    wait_resp(4);
    tick();

    // Timeout, late beat drained, following request blocked until the drain completes.
    fork
      slave_txn(32'h0000_0020, 0, 20, 1'b1, 32'h5555_AAAA, 2'b00);
      begin
        issue(32'h0000_0020, 32'h0, 2'b11, 1'b1, 10, 1'b1);
        wait_resp(5);
        tick();
        issue(32'h0000_0024, 32'h7777_0024, 2'b00, 1'b0, -1, 1'b1);
        hs2 = req_hs;
      end
    join
    exp_ar++;
    chk("drain_blocks_req", 64'(hs2), 64'(r_beat_cyc + 1));
    slave_txn(32'h0000_0024, 0, 0, 1'b1, 32'h7777_0024, 2'b00);
    exp_ar++;
    wait_resp(6);
    tick();

    // Reset while waiting for R, then a fresh request with an EXOKAY response.
    fork
      slave_txn(32'h0000_0030, 0, 0, 1'b0, 32'h0, 2'b00);
      issue(32'h0000_0030, 32'h0, 2'b00, 1'b0, -1, 1'b0);
    join
    exp_ar++;
    chk("rready_in_rwait", 64'(rready), 64'(1));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    tick();
    fork
      slave_txn(32'h0000_0034, 0, 0, 1'b1, 32'h3434_0000, 2'b01);
      issue(32'h0000_0034, 32'h3434_0000, 2'b00, 1'b0, 3, 1'b1);
    join
    exp_ar++;
    wait_resp(7);
    tick();

    // DECERR from the slave after two wait cycles.
    fork
      slave_txn(32'h0000_0040, 0, 2, 1'b1, 32'hFFFF_0000, 2'b11);
      issue(32'h0000_0040, 32'h0, 2'b11, 1'b0, 5, 1'b1);
    join
    exp_ar++;
    wait_resp(8);
    tick();

    chk("ar_count_total", 64'(ar_count), 64'(exp_ar));
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
